// File: rtl/stdp_weight_sched.sv
// stdp_weight_sched: walks pending STDP inc/dec requests through a single-port weight RAM with saturating read-modify-write
module stdp_weight_sched #(
  parameter int WRES = 3,
  parameter int P = 8,
  localparam int AW = $clog2(P)
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            grst,
  input  logic            learn_en,
  input  logic [P-1:0]    inc_vec,
  input  logic [P-1:0]    dec_vec,
  output logic [AW-1:0]   wmem_addr,
  output logic            wmem_re,
  input  logic [WRES-1:0] wmem_rdata,
  output logic            wmem_we,
  output logic [WRES-1:0] wmem_wdata,
  output logic            busy,
  output logic            done,
  output logic [AW:0]     upd_count,
  output logic            overrun
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam logic [WRES-1:0] WMAX = '1;
  state_t state, state_n;
  logic [P-1:0] pend, inc_s, dec_s;
  logic [AW:0] cnt;
  logic [AW-1:0] addr_q, lsb;
  logic [WRES-1:0] wdata_q;
  logic start, up, dn;
  assign start = grst && learn_en && state == IDLE;
  // lowest pending synapse index, served next
  always_comb begin
    lsb = '0;
    for (int i = P - 1; i >= 0; i--) if (pend[i]) lsb = AW'(i);
  end
  // next state: one READ/WRITE pair per pending synapse, then a single DONE cycle
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (start ? ((inc_vec ^ dec_vec) != '0 ? READ : DONE) : IDLE) :
              state == READ  ? WRITE :
              state == WRITE ? (pend != '0 ? READ : DONE) : IDLE;
  end
  // pending synapses have exactly one request bit, so up and dn never coincide
  assign up = inc_s[addr_q] && wmem_rdata != WMAX;
  assign dn = dec_s[addr_q] && wmem_rdata != '0;
  assign wmem_re = rstb && state == READ;
  assign wmem_we = rstb && state == WRITE && (up || dn);
  assign wmem_addr = state == READ ? lsb : addr_q;
  assign wmem_wdata = wmem_we ? (up ? wmem_rdata + WRES'(1) : wmem_rdata - WRES'(1)) : wdata_q;
  assign busy = state == READ || state == WRITE;
  assign done = state == DONE;
  // state register
  always_ff @(posedge clk) begin
    if (!rstb) state <= IDLE;
    else state <= state_n;
  end
  // request snapshot, pending walk, write counter and status flags
  always_ff @(posedge clk) begin
    if (!rstb) begin
      pend <= '0;
      inc_s <= '0;
      dec_s <= '0;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      upd_count <= '0;
      overrun <= 1'b0;
    end else begin
      addr_q <= wmem_addr;
      wdata_q <= wmem_wdata;
      if (start) begin
        inc_s <= inc_vec;
        dec_s <= dec_vec;
        pend <= inc_vec ^ dec_vec;
      end
      if (state == READ) pend[lsb] <= 1'b0;
      if (grst && state != IDLE) overrun <= 1'b1;
      cnt <= state == DONE ? '0 : cnt + (AW + 1)'(wmem_we);
      if (state == DONE) upd_count <= cnt;
    end
  end
endmodule

// File: tb/tb_stdp_weight_sched.sv
// tb_stdp_weight_sched: directed sweeps against a behavioural weight RAM with hand-computed results
module tb_stdp_weight_sched;
  logic clk = 1'b0, rstb = 1'b0, grst = 1'b0, learn_en = 1'b0;
  logic [7:0] inc_vec = '0, dec_vec = '0;
  logic [2:0] wmem_addr, wmem_wdata, wmem_rdata = '0;
  logic wmem_re, wmem_we, busy, done, overrun;
  logic [3:0] upd_count;
  logic [2:0] mem [8];
  int total = 0, bad = 0;
  int wa[$], wd[$];
  int dcyc, nre, nbusy, ra0;

  stdp_weight_sched dut (
    .clk(clk), .rstb(rstb), .grst(grst), .learn_en(learn_en),
    .inc_vec(inc_vec), .dec_vec(dec_vec),
    .wmem_addr(wmem_addr), .wmem_re(wmem_re), .wmem_rdata(wmem_rdata),
    .wmem_we(wmem_we), .wmem_wdata(wmem_wdata),
    .busy(busy), .done(done), .upd_count(upd_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wmem_re) wmem_rdata <= mem[wmem_addr];
    if (wmem_we) mem[wmem_addr] <= wmem_wdata;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 8; i++) mem[i] = 3'(v);
  endtask

  // pulse grst, log every access until done (bounded), optionally pulse grst again at cycle gcyc
  task automatic sweep(input logic le, input logic [7:0] iv, input logic [7:0] dv, input int gcyc);
    wa.delete();
    wd.delete();
    nre = 0; nbusy = 0; dcyc = -1; ra0 = -1;
    learn_en = le; inc_vec = iv; dec_vec = dv; grst = 1'b1;
    step();
    grst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (wmem_re) begin
        if (ra0 < 0) ra0 = wmem_addr;
        nre++;
      end
      if (busy) nbusy++;
      if (wmem_we) begin
        wa.push_back(wmem_addr);
        wd.push_back(wmem_wdata);
      end
      if (wmem_re && wmem_we) chk("re_we_exclusive", 1, 0);
      if (done) begin
        dcyc = c;
        break;
      end
      if (c == gcyc) begin
        grst = 1'b1; inc_vec = 8'hFF; dec_vec = 8'h00;
      end
      step();
      grst = 1'b0;
    end
    step();
  endtask

  initial begin
    fill(0);
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re", wmem_re, 0);
    chk("rst_we", wmem_we, 0);
    chk("rst_addr", wmem_addr, 0);
    chk("rst_wdata", wmem_wdata, 0);
    chk("rst_upd", upd_count, 0);
    chk("rst_ovr", overrun, 0);
    rstb = 1'b1;
    step();

    mem[0] = 3; mem[2] = 7;
    sweep(1, 8'h05, 8'h00, 0);
    chk("t1_done_cyc", dcyc, 5);
    chk("t1_reads", nre, 2);
    chk("t1_nwr", wa.size(), 1);
    if (wa.size() > 0) begin
      chk("t1_waddr", wa[0], 0);
      chk("t1_wdata", wd[0], 4);
    end
    chk("t1_upd", upd_count, 1);
    chk("t1_mem0", mem[0], 4);
    chk("t1_mem2", mem[2], 7);
    chk("t1_done_low", done, 0);

    sweep(1, 8'h81, 8'h81, 0);
    chk("t2_done_cyc", dcyc, 1);
    chk("t2_reads", nre, 0);
    chk("t2_nwr", wa.size(), 0);
    chk("t2_upd", upd_count, 0);

    fill(1);
    sweep(1, 8'h00, 8'hFF, 0);
    chk("t3_done_cyc", dcyc, 17);
    chk("t3_nwr", wa.size(), 8);
    for (int i = 0; i < wa.size(); i++) begin
      chk("t3_waddr", wa[i], i);
      chk("t3_wdata", wd[i], 0);
    end
    chk("t3_upd", upd_count, 8);
    sweep(1, 8'h00, 8'hFF, 0);
    chk("t3z_done_cyc", dcyc, 17);
    chk("t3z_reads", nre, 8);
    chk("t3z_nwr", wa.size(), 0);
    chk("t3z_upd", upd_count, 0);

    mem[1] = 0; mem[3] = 7; mem[5] = 2;
    sweep(1, 8'h28, 8'h02, 0);
    chk("t4_done_cyc", dcyc, 7);
    chk("t4_nwr", wa.size(), 1);
    if (wa.size() > 0) chk("t4_waddr", wa[0], 5);
    chk("t4_mem1", mem[1], 0);
    chk("t4_mem3", mem[3], 7);
    chk("t4_mem5", mem[5], 3);
    chk("t4_upd", upd_count, 1);
    chk("t4_ovr_clear", overrun, 0);

    fill(1);
    sweep(1, 8'h00, 8'hFF, 4);
    chk("t5_done_cyc", dcyc, 17);
    chk("t5_nwr", wa.size(), 8);
    for (int i = 0; i < wa.size(); i++) chk("t5_wdata", wd[i], 0);
    chk("t5_upd", upd_count, 8);
    chk("t5_ovr", overrun, 1);
    sweep(1, 8'h01, 8'h00, 0);
    chk("t5_next_mem0", mem[0], 1);
    chk("t5_ovr_sticky", overrun, 1);

    fill(1);
    learn_en = 1'b1; inc_vec = 8'h00; dec_vec = 8'hFF; grst = 1'b1;
    step();
    grst = 1'b0;
    for (int c = 1; c < 6; c++) step();
    chk("t6_in_write", busy, 1);
    rstb = 1'b0;
    #1;
    chk("t6_we_in_rst", wmem_we, 0);
    step();
    rstb = 1'b1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_re", wmem_re, 0);
    chk("t6_we", wmem_we, 0);
    chk("t6_addr", wmem_addr, 0);
    chk("t6_wdata", wmem_wdata, 0);
    chk("t6_upd", upd_count, 0);
    chk("t6_ovr", overrun, 0);
    for (int c = 0; c < 5; c++) step();
    chk("t6_mem1", mem[1], 0);
    chk("t6_mem2", mem[2], 1);
    chk("t6_idle", busy, 0);
    sweep(1, 8'h00, 8'hFF, 0);
    chk("t6_first_read", ra0, 0);
    chk("t6_nwr", wa.size(), 6);
    if (wa.size() > 0) chk("t6_first_write", wa[0], 2);
    chk("t6_done_cyc", dcyc, 17);
    chk("t6_upd2", upd_count, 6);

    fill(3);
    sweep(0, 8'hFF, 8'h00, 0);
    chk("t7_no_done", dcyc, -1);
    chk("t7_reads", nre, 0);
    chk("t7_nwr", wa.size(), 0);
    chk("t7_busy", nbusy, 0);
    chk("t7_upd", upd_count, 6);
    chk("t7_mem0", mem[0], 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
